// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the UART peripheral.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned W_DATA  = 8;
    localparam int unsigned W_DVSR  = 16;
    localparam int unsigned OVRSMPL = 16;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
`ifdef UART_PARITY_EN
        RxParity,
`endif
        RxStop
    } rx_state_t;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
`ifdef UART_PARITY_EN
        TxParity,
`endif
        TxStop
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags.
// Writes when full are dropped unless a read happens in the same cycle.
module uart_fifo #(
    parameter int unsigned W_DATA = 8,
    parameter int unsigned W_ADDR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              wr,
    input  logic [W_DATA-1:0] w_data,
    output logic [W_DATA-1:0] r_data,
    output logic              empty,
    output logic              full
);
    import uart_pkg::*;

    localparam logic [W_ADDR-1:0] PTR_ONE = W_ADDR'(1);

    logic [W_DATA-1:0] mem [2**W_ADDR];
    logic [W_ADDR-1:0] w_ptr;
    logic [W_ADDR-1:0] r_ptr;
    logic              wr_en;
    logic              rd_en;

    assign wr_en  = wr && (!full || rd);
    assign rd_en  = rd && !empty;
    assign r_data = mem[r_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**W_ADDR; i++) begin
                mem[i] <= '0;
            end
            w_ptr <= '0;
            r_ptr <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[w_ptr] <= w_data;
                w_ptr      <= w_ptr + PTR_ONE;
            end
            if (rd_en) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= (w_ptr + PTR_ONE == r_ptr);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= (r_ptr + PTR_ONE == w_ptr);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_top.sv
// Full-duplex UART: baud generator, 16x oversampling receiver, transmitter, Rx/Tx FIFOs.
// Define UART_PARITY_EN for 8E1 framing; otherwise frames are 8N1 and parity_error is 0.
module uart_top #(
    parameter int unsigned W_DATA = uart_pkg::W_DATA,
    parameter int unsigned W_DVSR = uart_pkg::W_DVSR,
    parameter int unsigned W_ADDR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_DVSR-1:0] dvsr,
    input  logic              Rx_din,
    input  logic              rd_uart,
    input  logic              wr_uart,
    input  logic [W_DATA-1:0] wr_data,
    output logic [W_DATA-1:0] rd_data,
    output logic              Tx_dout,
    output logic              Rx_full,
    output logic              Rx_empty,
    output logic              Tx_full,
    output logic              parity_error,
    output logic              framing_error
);
    import uart_pkg::*;

    localparam int unsigned       W_CNT   = $clog2(W_DATA);
    localparam logic [3:0]        S_MID   = 4'(OVRSMPL / 2 - 1);
    localparam logic [3:0]        S_END   = 4'(OVRSMPL - 1);
    localparam logic [W_CNT-1:0]  N_END   = W_CNT'(W_DATA - 1);
    localparam logic [W_CNT-1:0]  N_ONE   = W_CNT'(1);
    localparam logic [W_DVSR:0]   CNT_ONE = (W_DVSR + 1)'(1);

    // Baud generator: tick every 2*dvsr clocks, every clock when dvsr is 0
    logic [W_DVSR:0] baud_cnt;
    logic [W_DVSR:0] baud_lim;
    logic            tick;

    assign baud_lim = {dvsr, 1'b0} - CNT_ONE;
    assign tick     = (dvsr == '0) || (baud_cnt >= baud_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + CNT_ONE;
        end
    end

    // Receiver
    rx_state_t         rx_state;
    logic [3:0]        rx_s;
    logic [W_CNT-1:0]  rx_n;
    logic [W_DATA-1:0] rx_shift;
    logic              rx_push;
`ifdef UART_PARITY_EN
    logic              rx_par;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state      <= RxIdle;
            rx_s          <= '0;
            rx_n          <= '0;
            rx_shift      <= '0;
            rx_push       <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par        <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
            unique case (rx_state)
                RxIdle: begin
                    if (!Rx_din) begin
                        rx_state <= RxStart;
                        rx_s     <= '0;
                    end
                end
                RxStart: begin
                    if (tick) begin
                        if (rx_s == S_MID) begin
                            // Line back high at mid-start: treat as a glitch
                            rx_state <= Rx_din ? RxIdle : RxData;
                            rx_s     <= '0;
                            rx_n     <= '0;
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
                RxData: begin
                    if (tick) begin
                        if (rx_s == S_END) begin
                            rx_s     <= '0;
                            rx_shift <= {Rx_din, rx_shift[W_DATA-1:1]};
                            if (rx_n == N_END) begin
`ifdef UART_PARITY_EN
                                rx_state <= RxParity;
`else
                                rx_state <= RxStop;
`endif
                            end else begin
                                rx_n <= rx_n + N_ONE;
                            end
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RxParity: begin
                    if (tick) begin
                        if (rx_s == S_END) begin
                            rx_s     <= '0;
                            rx_par   <= Rx_din;
                            rx_state <= RxStop;
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
`endif
                RxStop: begin
                    if (tick) begin
                        if (rx_s == S_END) begin
                            rx_state      <= RxIdle;
                            rx_push       <= 1'b1;
                            framing_error <= !Rx_din;
`ifdef UART_PARITY_EN
                            parity_error  <= (^rx_shift) != rx_par;
`endif
                        end else begin
                            rx_s <= rx_s + 4'd1;
                        end
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign parity_error = 1'b0;
`endif

    uart_fifo #(
        .W_DATA(W_DATA),
        .W_ADDR(W_ADDR)
    ) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .rd    (rd_uart),
        .wr    (rx_push),
        .w_data(rx_shift),
        .r_data(rd_data),
        .empty (Rx_empty),
        .full  (Rx_full)
    );

    // Transmitter
    tx_state_t         tx_state;
    logic [3:0]        tx_s;
    logic [W_CNT-1:0]  tx_n;
    logic [W_DATA-1:0] tx_shift;
    logic [W_DATA-1:0] tx_head;
    logic              tx_empty;
    logic              tx_pop;
`ifdef UART_PARITY_EN
    logic              tx_par;
`endif

    // Loads are tick-aligned so every bit lasts exactly 16 ticks; a queued word
    // follows the stop bit with no idle gap.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state == TxIdle) || ((tx_state == TxStop) && (tx_s == S_END)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TxIdle;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_shift <= '0;
            Tx_dout  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_pop) begin
            tx_state <= TxStart;
            tx_s     <= '0;
            tx_shift <= tx_head;
            Tx_dout  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_head;
`endif
        end else begin
            unique case (tx_state)
                TxIdle: Tx_dout <= 1'b1;
                TxStart: begin
                    if (tick) begin
                        if (tx_s == S_END) begin
                            tx_s     <= '0;
                            tx_n     <= '0;
                            tx_state <= TxData;
                            Tx_dout  <= tx_shift[0];
                        end else begin
                            tx_s <= tx_s + 4'd1;
                        end
                    end
                end
                TxData: begin
                    if (tick) begin
                        if (tx_s == S_END) begin
                            tx_s <= '0;
                            if (tx_n == N_END) begin
`ifdef UART_PARITY_EN
                                tx_state <= TxParity;
                                Tx_dout  <= tx_par;
`else
                                tx_state <= TxStop;
                                Tx_dout  <= 1'b1;
`endif
                            end else begin
                                tx_n     <= tx_n + N_ONE;
                                tx_shift <= tx_shift >> 1;
                                Tx_dout  <= tx_shift[1];
                            end
                        end else begin
                            tx_s <= tx_s + 4'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TxParity: begin
                    if (tick) begin
                        if (tx_s == S_END) begin
                            tx_s     <= '0;
                            tx_state <= TxStop;
                            Tx_dout  <= 1'b1;
                        end else begin
                            tx_s <= tx_s + 4'd1;
                        end
                    end
                end
`endif
                TxStop: begin
                    if (tick) begin
                        if (tx_s == S_END) begin
                            tx_state <= TxIdle;
                        end else begin
                            tx_s <= tx_s + 4'd1;
                        end
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    uart_fifo #(
        .W_DATA(W_DATA),
        .W_ADDR(W_ADDR)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .rd    (tx_pop),
        .wr    (wr_uart),
        .w_data(wr_data),
        .r_data(tx_head),
        .empty (tx_empty),
        .full  (Tx_full)
    );

endmodule

// File: tb/tb_uart_top.sv
// Scoreboard bench for uart_top: Rx frames are bit-banged on Rx_din, Tx frames decoded off Tx_dout.
// Follows UART_PARITY_EN to choose between 8E1 and 8N1 framing.
module tb_uart_top;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dvsr;
    logic        Rx_din;
    logic        rd_uart;
    logic        wr_uart;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        Tx_dout;
    logic        Rx_full;
    logic        Rx_empty;
    logic        Tx_full;
    logic        parity_error;
    logic        framing_error;

    int          n_vec = 0;
    int          n_err = 0;
    int          bit_clks;
    int          rx_cnt = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    uart_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dvsr         (dvsr),
        .Rx_din       (Rx_din),
        .rd_uart      (rd_uart),
        .wr_uart      (wr_uart),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .Tx_dout      (Tx_dout),
        .Rx_full      (Rx_full),
        .Rx_empty     (Rx_empty),
        .Tx_full      (Tx_full),
        .parity_error (parity_error),
        .framing_error(framing_error)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A bad stop bit is held only past its mid-point so the trailing low level
    // falls into glitch rejection rather than starting a new frame.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
        logic exp_perr;
        Rx_din = 1'b0;
        idle(bit_clks);
        for (int i = 0; i < 8; i++) begin
            Rx_din = d[i];
            idle(bit_clks);
        end
`ifdef UART_PARITY_EN
        Rx_din = (^d) ^ par_flip;
        idle(bit_clks);
        exp_perr = par_flip;
`else
        exp_perr = 1'b0 & par_flip;
`endif
        Rx_din = stop_bit;
        idle(stop_bit ? bit_clks : (bit_clks * 5) / 8);
        Rx_din = 1'b1;
        idle(bit_clks);
        if (rx_cnt < 4) begin
            rx_q.push_back(d);
            rx_cnt++;
        end
        check("parity_error", 16'(parity_error), 16'(exp_perr));
        check("framing_error", 16'(framing_error), 16'(!stop_bit));
    endtask

    task automatic rx_read();
        check("rx_word_available", 16'(rx_q.size() != 0), 16'd1);
        if (rx_q.size() != 0) begin
            check("rd_data", 16'(rd_data), 16'(rx_q.pop_front()));
            rd_uart = 1'b1;
            idle(1);
            rd_uart = 1'b0;
            rx_cnt--;
        end
    endtask

    task automatic tx_monitor(input int nframes, input int bclk);
        logic [7:0] d;
        int         w;
        for (int f = 0; f < nframes; f++) begin
            w = 0;
            while (Tx_dout !== 1'b0 && w < 4000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 4000) begin
                check("tx_start_seen", 16'(Tx_dout), 16'd0);
                return;
            end
            idle(bclk / 2);
            check("tx_start_bit", 16'(Tx_dout), 16'd0);
            for (int i = 0; i < 8; i++) begin
                idle(bclk);
                d[i] = Tx_dout;
            end
            check("tx_word_expected", 16'(tx_q.size() != 0), 16'd1);
            if (tx_q.size() != 0) begin
                check("tx_data", 16'(d), 16'(tx_q.pop_front()));
            end
`ifdef UART_PARITY_EN
            idle(bclk);
            check("tx_parity", 16'(Tx_dout), 16'(^d));
`endif
            idle(bclk);
            check("tx_stop_bit", 16'(Tx_dout), 16'd1);
        end
    endtask

    initial begin
        int lat;
        rst_n    = 1'b0;
        dvsr     = 16'd2;
        bit_clks = 64;
        Rx_din   = 1'b1;
        rd_uart  = 1'b0;
        wr_uart  = 1'b0;
        wr_data  = 8'h00;
        idle(3);
        check("rst_Tx_dout", 16'(Tx_dout), 16'd1);
        check("rst_Rx_empty", 16'(Rx_empty), 16'd1);
        check("rst_Rx_full", 16'(Rx_full), 16'd0);
        check("rst_Tx_full", 16'(Tx_full), 16'd0);
        check("rst_parity_error", 16'(parity_error), 16'd0);
        check("rst_framing_error", 16'(framing_error), 16'd0);
        check("rst_rd_data", 16'(rd_data), 16'd0);
        rst_n = 1'b1;
        idle(5);

        // Clean frame, parity error, framing error, clean again
        send_frame(8'hA5, 1'b0, 1'b1);
        check("rx_not_empty", 16'(Rx_empty), 16'd0);
        rx_read();
        check("rx_empty_after_read", 16'(Rx_empty), 16'd1);
        send_frame(8'h3C, 1'b1, 1'b1);
        rx_read();
        send_frame(8'h5E, 1'b0, 1'b0);
        rx_read();
        send_frame(8'h81, 1'b0, 1'b1);
        rx_read();

        // Overflow: six frames into a four-deep FIFO
        for (int k = 1; k <= 6; k++) begin
            send_frame(8'(k * 17), 1'b0, 1'b1);
            if (k == 3) check("rx_full_after_3", 16'(Rx_full), 16'd0);
            if (k == 4) check("rx_full_after_4", 16'(Rx_full), 16'd1);
        end
        for (int k = 0; k < 4; k++) rx_read();
        check("rx_empty_after_drain", 16'(Rx_empty), 16'd1);

        // Tx: one word, then a burst while busy, then writes held across a pop on a full FIFO
        fork
            tx_monitor(6, bit_clks);
            begin
                wr_data = 8'h5A;
                wr_uart = 1'b1;
                tx_q.push_back(8'h5A);
                idle(1);
                wr_uart = 1'b0;
                lat = 0;
                while (Tx_dout !== 1'b0 && lat < 20) begin
                    idle(1);
                    lat++;
                end
                check("tx_latency_ok", 16'(lat <= 6), 16'd1);
                idle(2);
                for (int i = 1; i <= 6; i++) begin
                    wr_data = 8'(i);
                    wr_uart = 1'b1;
                    if (i <= 4) tx_q.push_back(8'(i));
                    idle(1);
                end
                wr_uart = 1'b0;
                check("tx_full_after_burst", 16'(Tx_full), 16'd1);
                wr_data = 8'h77;
                wr_uart = 1'b1;
                tx_q.push_back(8'h77);
                for (int c = 0; c < FRAME_BITS * bit_clks; c++) begin
                    idle(1);
                    check("tx_full_rd_wr", 16'(Tx_full), 16'd1);
                end
                wr_uart = 1'b0;
            end
        join
        check("tx_q_drained", 16'(tx_q.size()), 16'd0);
        idle(bit_clks);

        // dvsr = 0: one tick per clock, 16 clocks per bit
        dvsr     = 16'd0;
        bit_clks = 16;
        fork
            tx_monitor(1, bit_clks);
            begin
                wr_data = 8'hC3;
                wr_uart = 1'b1;
                tx_q.push_back(8'hC3);
                idle(1);
                wr_uart = 1'b0;
            end
        join
        idle(bit_clks);

        // Reset mid-frame aborts Tx and discards FIFO contents
        send_frame(8'h42, 1'b0, 1'b1);
        check("rx_word_pending", 16'(Rx_empty), 16'd0);
        wr_data = 8'h00;
        wr_uart = 1'b1;
        idle(1);
        wr_uart = 1'b0;
        lat = 0;
        while (Tx_dout !== 1'b0 && lat < 20) begin
            idle(1);
            lat++;
        end
        check("tx_midframe_started", 16'(Tx_dout), 16'd0);
        idle(3);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_Tx_dout", 16'(Tx_dout), 16'd1);
        check("async_rst_Rx_empty", 16'(Rx_empty), 16'd1);
        check("async_rst_rd_data", 16'(rd_data), 16'd0);
        rx_q.delete();
        rx_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
